// File: rtl/demux32_stream_1by2.sv
// 32-bit 1-to-2 stream demultiplexer: in_ctl steers each accepted word into one of two
// independent output FIFOs, each with its own accepted-word counter.
module demux32_stream_1by2 #(
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_ctl,
    input  logic [31:0]   in_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [31:0]   out0_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [31:0]   out1_data,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem0 [DEPTH];
    logic [31:0] mem1 [DEPTH];
    logic [AW:0] wr0, rd0, wr1, rd1;
    logic        full0, full1, empty0, empty1;
    logic        push0, push1, pop0, pop1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full0  = (wr0[AW-1:0] == rd0[AW-1:0]) && (wr0[AW] != rd0[AW]);
    assign full1  = (wr1[AW-1:0] == rd1[AW-1:0]) && (wr1[AW] != rd1[AW]);
    assign empty0 = (wr0 == rd0);
    assign empty1 = (wr1 == rd1);

    assign in_ready = in_ctl ? !full1 : !full0;
    assign push0    = in_valid && !in_ctl && !full0;
    assign push1    = in_valid &&  in_ctl && !full1;
    assign pop0     = !empty0 && out0_ready;
    assign pop1     = !empty1 && out1_ready;

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign out0_data  = empty0 ? 32'd0 : mem0[rd0[AW-1:0]];
    assign out1_data  = empty1 ? 32'd0 : mem1[rd1[AW-1:0]];

    // Storage needs no reset: the empty flag masks stale entries on the outputs.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem0[wr0[AW-1:0]] <= in_data;
        end
        if (push1) begin
            mem1[wr1[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr0  <= '0;
            rd0  <= '0;
            wr1  <= '0;
            rd1  <= '0;
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push0) begin
                wr0  <= wr0 + 1'b1;
                cnt0 <= cnt0 + 1'b1;
            end
            if (push1) begin
                wr1  <= wr1 + 1'b1;
                cnt1 <= cnt1 + 1'b1;
            end
            if (pop0) begin
                rd0 <= rd0 + 1'b1;
            end
            if (pop1) begin
                rd1 <= rd1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux32_stream_1by2.sv
// Self-checking bench for demux32_stream_1by2: a queue-based model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_demux32_stream_1by2;

    localparam int DEPTH = 2;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic          inCtl = 1'b0;
    logic [31:0]   inData = '0;
    logic          out0Valid;
    logic          out0Ready = 1'b0;
    logic [31:0]   out0Data;
    logic          out1Valid;
    logic          out1Ready = 1'b0;
    logic [31:0]   out1Data;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int nChecks = 0;
    int nFails  = 0;
    bit toggle0 = 1'b0;

    // Model state: pending words per output, delivered words per output, counters.
    logic [31:0]   q0[$];
    logic [31:0]   q1[$];
    logic [31:0]   del0[$];
    logic [31:0]   del1[$];
    logic [CW-1:0] m0 = '0;
    logic [CW-1:0] m1 = '0;
    bit            live = 1'b0;
    bit            acc0, acc1, pop0, pop1;

    demux32_stream_1by2 #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(inValid), .in_ready(inReady), .in_ctl(inCtl), .in_data(inData),
        .out0_valid(out0Valid), .out0_ready(out0Ready), .out0_data(out0Data),
        .out1_valid(out1Valid), .out1_ready(out1Ready), .out1_data(out1Data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: pops and pushes are decided from the pre-edge occupancy.
    always @(posedge clk) begin
        if (reset) begin
            q0.delete(); q1.delete(); del0.delete(); del1.delete();
            m0 = '0; m1 = '0;
            live = 1'b1;
        end else if (live) begin
            acc0 = inValid && !inCtl && (q0.size() < DEPTH);
            acc1 = inValid &&  inCtl && (q1.size() < DEPTH);
            pop0 = (q0.size() > 0) && out0Ready;
            pop1 = (q1.size() > 0) && out1Ready;
            if (pop0) del0.push_back(q0.pop_front());
            if (pop1) del1.push_back(q1.pop_front());
            if (acc0) begin q0.push_back(inData); m0 = m0 + 1'b1; end
            if (acc1) begin q1.push_back(inData); m1 = m1 + 1'b1; end
        end
    end

    always @(negedge clk) begin
        if (live && !reset) begin
            checkOutput("in_ready", 32'(inReady),
                        32'(inCtl ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
            checkOutput("out0_valid", 32'(out0Valid), 32'(q0.size() > 0));
            checkOutput("out0_data", out0Data, (q0.size() > 0) ? q0[0] : 32'd0);
            checkOutput("out1_valid", 32'(out1Valid), 32'(q1.size() > 0));
            checkOutput("out1_data", out1Data, (q1.size() > 0) ? q1[0] : 32'd0);
            checkOutput("cnt0", 32'(cnt0), 32'(m0));
            checkOutput("cnt1", 32'(cnt1), 32'(m1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle0) out0Ready = !out0Ready;
    endtask

    task automatic resetDut();
        inValid = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Presents one word and holds it until the DUT takes it, within a cycle budget.
    task automatic applyStimulus(input logic ctl, input logic [31:0] d);
        bit done = 1'b0;
        inValid = 1'b1;
        inCtl   = ctl;
        inData  = d;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = inReady;
            tick();
        end
        inValid = 1'b0;
        if (!done) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Scenario 1: reset state and one word to each output.
        @(negedge clk);
        resetDut();
        checkOutput("rst_out0_valid", 32'(out0Valid), 32'd0);
        checkOutput("rst_out1_data", out1Data, 32'd0);
        checkOutput("rst_cnt0", 32'(cnt0), 32'd0);
        out0Ready = 1'b1;
        out1Ready = 1'b1;
        applyStimulus(1'b0, 32'hDEADBEEF);
        checkOutput("s1_out0_data", out0Data, 32'hDEADBEEF);
        checkOutput("s1_out1_valid", 32'(out1Valid), 32'd0);
        applyStimulus(1'b1, 32'h12345678);
        checkOutput("s1_out1_data", out1Data, 32'h12345678);
        checkOutput("s1_out0_valid", 32'(out0Valid), 32'd0);
        checkOutput("s1_cnt0", 32'(cnt0), 32'd1);
        checkOutput("s1_cnt1", 32'(cnt1), 32'd1);
        tick();

        // Scenario 2/3: head-of-line stall on out0, out1 still flows, then push-while-full.
        resetDut();
        out0Ready = 1'b0;
        out1Ready = 1'b1;
        applyStimulus(1'b0, 32'h1);
        applyStimulus(1'b0, 32'h2);
        inValid = 1'b1; inCtl = 1'b0; inData = 32'h3;
        @(negedge clk);
        checkOutput("s2_in_ready_full", 32'(inReady), 32'd0);
        tick();
        applyStimulus(1'b1, 32'hA);
        checkOutput("s2_out1_data", out1Data, 32'hA);
        checkOutput("s2_out0_head", out0Data, 32'h1);
        out0Ready = 1'b1;
        applyStimulus(1'b0, 32'h3);
        checkOutput("s3_out0_head", out0Data, 32'h3);
        checkOutput("s3_cnt0", 32'(cnt0), 32'd3);
        tick();
        tick();
        checkOutput("s3_del0_size", 32'(del0.size()), 32'd3);
        for (int i = 0; i < 3 && i < del0.size(); i++) begin
            checkOutput("s3_del0_order", del0[i], 32'(i + 1));
        end
        checkOutput("s3_del1_word", (del1.size() > 0) ? del1[0] : 32'hFFFFFFFF, 32'hA);

        // Scenario 4: ten words through out0 with a toggling consumer, across pointer wrap.
        resetDut();
        out0Ready = 1'b0;
        toggle0   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h100 + 32'(i));
        end
        for (int i = 0; i < 40 && q0.size() > 0; i++) begin
            tick();
        end
        toggle0 = 1'b0;
        checkOutput("s4_cnt0", 32'(cnt0), 32'd10);
        checkOutput("s4_del0_size", 32'(del0.size()), 32'd10);
        for (int i = 0; i < 10 && i < del0.size(); i++) begin
            checkOutput("s4_del0_order", del0[i], 32'h100 + 32'(i));
        end

        // Scenario 5: 256 words to out1 wrap its counter back to zero.
        resetDut();
        out1Ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 32'(i * 3));
        end
        tick();
        checkOutput("s5_cnt1_wrap", 32'(cnt1), 32'd0);
        checkOutput("s5_cnt0", 32'(cnt0), 32'd0);
        checkOutput("s5_del1_last", (del1.size() == 256) ? del1[255] : 32'hFFFFFFFF, 32'd765);

        // Scenario 6: reset discards buffered words on out1.
        resetDut();
        out1Ready = 1'b0;
        applyStimulus(1'b1, 32'hCAFE0001);
        applyStimulus(1'b1, 32'hCAFE0002);
        checkOutput("s6_out1_pre", out1Data, 32'hCAFE0001);
        resetDut();
        checkOutput("s6_out1_valid", 32'(out1Valid), 32'd0);
        checkOutput("s6_out1_data", out1Data, 32'd0);
        checkOutput("s6_cnt1", 32'(cnt1), 32'd0);
        out1Ready = 1'b1;
        tick();
        tick();
        checkOutput("s6_del1_none", 32'(del1.size()), 32'd0);
        checkOutput("s6_out1_still", 32'(out1Valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/demux32_stream_1by2.md
Name: demux32_stream_1by2

Overview:
- 32-bit 1-to-2 demultiplexer with buffering and flow control, the inverse of the 32-bit 2:1 word mux.
- Accepts one 32-bit word per handshake on a single input port and steers it by `in_ctl` to one of two output ports.
- Each output has its own small FIFO, so the two consumers can stall independently.
- Sits in the ALU datapath to split a result stream between two consumers, e.g. the register writeback path and the flag/compare path.

Parameters:
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- CW, 8, width of each per-output accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the word on the selected path.
- in_ctl  input  1  steer select: 0 routes to out0, 1 routes to out1; same convention as the 2:1 mux (ctl=1 selects the I1 side).
- in_data  input  32  input word.
- out0_valid  output  1  out0 FIFO non-empty.
- out0_ready  input  1  consumer 0 accepts the head word.
- out0_data  output  32  out0 FIFO head word.
- out1_valid  output  1  out1 FIFO non-empty.
- out1_ready  input  1  consumer 1 accepts the head word.
- out1_data  output  32  out1 FIFO head word.
- cnt0  output  CW  count of words accepted toward out0.
- cnt1  output  CW  count of words accepted toward out1.

Behaviour:
- Reset (reset=1 at a clk edge):
  - Both FIFOs emptied; all read and write pointers cleared to 0.
  - out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0.
  - Reset overrides any handshake in the same cycle; words in flight are discarded, not delivered.
- Input handshake:
  - in_ready = !full(FIFO selected by in_ctl). This is combinational from in_ctl and the FIFO state only; it never depends on in_valid or on out*_ready.
  - A word is accepted on a clk edge where in_valid && in_ready. in_data is written to the tail of the selected FIFO.
  - On acceptance, the selected counter increments by 1 and wraps modulo 2^CW (all-ones + 1 = 0).
- Head-of-line blocking: if the selected FIFO is full, the input stalls even when the other FIFO has space. The producer must hold in_valid, in_ctl and in_data stable until accepted.
- Output handshake, per output k:
  - outk_valid = FIFO k non-empty.
  - outk_data = FIFO k head entry. It must read 0 when the FIFO is empty.
  - Pop occurs on a clk edge where outk_valid && outk_ready.
  - outk_ready while outk_valid=0 has no effect.
- Latency:
  - A word accepted at edge N into an empty FIFO appears at edge N with outk_valid=1 in the following cycle. That is 1 cycle, with no combinational bypass from input to output.
  - Words leave each FIFO in acceptance order. No ordering is guaranteed between out0 and out1.
- Simultaneous push and pop on the same FIFO:
  - Not full: both happen and occupancy is unchanged.
  - Full: push is refused (in_ready=0 that cycle); the pop still happens.
  - Empty: only the push happens (no bypass).
- Pointers are log2(DEPTH) bits wide plus one wrap bit. full means equal index and differing wrap bit; empty means pointers fully equal. Wrap-around past DEPTH-1 must preserve order.
- The two outputs and two counters operate fully independently; a stall on one never affects the other's pop.

Test Plan:
- Reset, then send 0xDEADBEEF with ctl=0 and 0x12345678 with ctl=1 on consecutive cycles, both out*_ready=1 -> out0 shows 0xDEADBEEF one cycle after its acceptance and out1 shows 0x12345678 one cycle after its acceptance; cnt0=1, cnt1=1; no valid on the wrong port.
- Hold out0_ready=0, send 3 words 0x1,0x2,0x3 with ctl=0 (DEPTH=2) -> 0x1 and 0x2 accepted and in_ready=0 for 0x3; then switch ctl=1 with word 0xA -> accepted to out1 while out0 still stalls; release out0_ready -> 0x1 then 0x2, then 0x3 is accepted.
- FIFO full with out0_ready=1 and in_valid=1, ctl=0 -> the pop occurs but the push is refused that cycle and accepted on the next edge; order is preserved.
- Stream 10 words to out0 with out0_ready toggled every cycle -> all 10 delivered in order across pointer wrap; cnt0=10.
- Send 256 words to out1 with CW=8 -> cnt1 wraps to 0; cnt0 stays 0.
- Two words buffered in out1, assert reset for one edge -> out1_valid=0, out1_data=0, cnt1=0 on the next cycle; the buffered words are never delivered.
